pwm_burst_monitor: RTL

Receive-side checker for the two-frequency PWM burst stream produced by the team's burst/soft-start generator. It samples an external PWM line and measures every rising-edge-to-rising-edge period and high time. Each pulse is classified as frequency A, frequency B or invalid. Runs of same-class pulses are reported as bursts, the block locks once a nominal A/B cycle is seen, and timing faults are flagged. It sits on the input side of the board, driving status LEDs and feeding a supervisor.

---
 rtl/pwm_burst_monitor.sv | 260 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/pwm_burst_monitor.sv
// pwm_burst_monitor
//   Receive-side checker for a two-frequency PWM burst stream. The external
//   PWM line is synchronised, then every rising-to-rising period and its high
//   time are measured. Each pulse is classified as frequency A, frequency B
//   or invalid. Runs of same-class pulses are reported as bursts. The block
//   locks once a nominal A burst is directly followed by a nominal B burst,
//   and it flags period, duty and timeout faults.
//
// Ports
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   pwm_in       asynchronous PWM line under test
//   clear_fault  synchronous pulse that clears fault / fault_code
//   burst_valid  one-cycle strobe qualifying burst_is_b / burst_len
//   burst_is_b   class of reported burst (0 = A, 1 = B)
//   burst_len    pulse count of reported burst, saturating at 255
//   locked       nominal A/B cycle detected
//   fault        sticky fault flag
//   fault_code   00 none, 01 period, 10 timeout, 11 duty
//   state_A_out  FSM is in IN_A
//   state_B_out  FSM is in IN_B
module pwm_burst_monitor #(
  parameter int CLK_SISTEMA_FREQ   = 12_000_000,
  parameter int FREQ_A             = 10,
  parameter int PULSES_A           = 10,
  parameter int FREQ_B             = 2,
  parameter int PULSES_B           = 5,
  parameter int DUTY_CYCLE_PERCENT = 50,
  parameter int TOL_PERCENT        = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pwm_in,
  input  logic       clear_fault,
  output logic       burst_valid,
  output logic       burst_is_b,
  output logic [7:0] burst_len,
  output logic       locked,
  output logic       fault,
  output logic [1:0] fault_code,
  output logic       state_A_out,
  output logic       state_B_out
);

  localparam int PER_A   = CLK_SISTEMA_FREQ / FREQ_A;
  localparam int PER_B   = CLK_SISTEMA_FREQ / FREQ_B;
  localparam int DUTY_A  = PER_A * DUTY_CYCLE_PERCENT / 100;
  localparam int DUTY_B  = PER_B * DUTY_CYCLE_PERCENT / 100;
  localparam int TOLP_A  = PER_A * TOL_PERCENT / 100;
  localparam int TOLP_B  = PER_B * TOL_PERCENT / 100;
  localparam int TIMEOUT = 2 * PER_B;
  localparam int CNT_W   = $clog2(TIMEOUT + 1);

  localparam logic [CNT_W-1:0] PA_LO     = CNT_W'(PER_A - TOLP_A);
  localparam logic [CNT_W-1:0] PA_HI     = CNT_W'(PER_A + TOLP_A);
  localparam logic [CNT_W-1:0] HA_LO     = CNT_W'(DUTY_A - TOLP_A);
  localparam logic [CNT_W-1:0] HA_HI     = CNT_W'(DUTY_A + TOLP_A);
  localparam logic [CNT_W-1:0] PB_LO     = CNT_W'(PER_B - TOLP_B);
  localparam logic [CNT_W-1:0] PB_HI     = CNT_W'(PER_B + TOLP_B);
  localparam logic [CNT_W-1:0] HB_LO     = CNT_W'(DUTY_B - TOLP_B);
  localparam logic [CNT_W-1:0] HB_HI     = CNT_W'(DUTY_B + TOLP_B);
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  localparam logic [7:0] NOM_A = 8'(PULSES_A);
  localparam logic [7:0] NOM_B = 8'(PULSES_B);

  localparam logic [1:0] WAIT_EDGE = 2'd0;
  localparam logic [1:0] MEASURE   = 2'd1;
  localparam logic [1:0] IN_A      = 2'd2;
  localparam logic [1:0] IN_B      = 2'd3;

  localparam logic [1:0] FC_PERIOD  = 2'b01;
  localparam logic [1:0] FC_TIMEOUT = 2'b10;
  localparam logic [1:0] FC_DUTY    = 2'b11;

  function automatic logic in_win(input logic [CNT_W-1:0] v,
                                  input logic [CNT_W-1:0] lo,
                                  input logic [CNT_W-1:0] hi);
    return (v >= lo) && (v <= hi);
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic             pwm_p0, pwm_p1, pwm_p2;
  logic             rise_det, fall_det;
  logic [CNT_W-1:0] period_cnt;
  logic [CNT_W-1:0] high_cnt;
  logic             fall_seen;
  logic [1:0]       state, state_nxt;
  logic [7:0]       run, run_nxt;
  logic             a_nom_prev;

  logic             per_is_a, per_is_b, duty_ok, timeout_hit;
  logic             emit, emit_b, emit_nom;
  logic             raise;
  logic [1:0]       raise_code;

  // Stage p0/p1: two-flop synchroniser. Stage p2: edge register; the
  // detect strobes are registered so an input edge shows up 3 clk later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_p0   <= 1'b0;
      pwm_p1   <= 1'b0;
      pwm_p2   <= 1'b0;
      rise_det <= 1'b0;
      fall_det <= 1'b0;
    end else begin
      pwm_p0   <= pwm_in;
      pwm_p1   <= pwm_p0;
      pwm_p2   <= pwm_p1;
      rise_det <= pwm_p1 & ~pwm_p2;
      fall_det <= ~pwm_p1 & pwm_p2;
    end
  end

  // Measurement stage: period_cnt holds the period length in the cycle of
  // the closing rise_det; fall_seen marks that a falling edge occurred.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      period_cnt <= '0;
      fall_seen  <= 1'b0;
    end else begin
      if (rise_det)
        period_cnt <= CNT_ONE;
      else if (period_cnt != TIMEOUT_C)
        period_cnt <= period_cnt + CNT_ONE;

      if (rise_det)
        fall_seen <= 1'b0;
      else if (fall_det)
        fall_seen <= 1'b1;
    end
  end

  // high_cnt is only consulted when fall_seen is set, so it needs no reset.
  always_ff @(posedge clk) begin
    if (fall_det)
      high_cnt <= period_cnt;
  end

  assign per_is_a = in_win(period_cnt, PA_LO, PA_HI);
  assign per_is_b = !per_is_a && in_win(period_cnt, PB_LO, PB_HI);
  assign duty_ok  = fall_seen &&
                    (per_is_a ? in_win(high_cnt, HA_LO, HA_HI)
                              : in_win(high_cnt, HB_LO, HB_HI));
  assign timeout_hit = (state != WAIT_EDGE) && (period_cnt == TIMEOUT_C);

  // Classification and burst tracking. A timeout pre-empts everything; a
  // bad period beats a bad duty cycle; a duty fault still lets the pulse
  // be classified and counted.
  always_comb begin
    state_nxt  = state;
    run_nxt    = run;
    emit       = 1'b0;
    emit_b     = 1'b0;
    raise      = 1'b0;
    raise_code = 2'b00;
    if (timeout_hit) begin
      raise      = 1'b1;
      raise_code = FC_TIMEOUT;
      state_nxt  = WAIT_EDGE;
      run_nxt    = 8'd0;
    end else if (rise_det) begin
      if (state == WAIT_EDGE) begin
        state_nxt = MEASURE;
      end else if (!per_is_a && !per_is_b) begin
        raise      = 1'b1;
        raise_code = FC_PERIOD;
        state_nxt  = MEASURE;
        run_nxt    = 8'd0;
      end else begin
        if (!duty_ok) begin
          raise      = 1'b1;
          raise_code = FC_DUTY;
        end
        case (state)
          MEASURE: begin
            state_nxt = per_is_a ? IN_A : IN_B;
            run_nxt   = 8'd1;
          end
          IN_A: begin
            if (per_is_a) begin
              run_nxt = sat_inc8(run);
            end else begin
              emit      = 1'b1;
              emit_b    = 1'b0;
              state_nxt = IN_B;
              run_nxt   = 8'd1;
            end
          end
          IN_B: begin
            if (per_is_b) begin
              run_nxt = sat_inc8(run);
            end else begin
              emit      = 1'b1;
              emit_b    = 1'b1;
              state_nxt = IN_A;
              run_nxt   = 8'd1;
            end
          end
          default: state_nxt = WAIT_EDGE;
        endcase
      end
    end
  end

  assign emit_nom = emit_b ? (run == NOM_B) : (run == NOM_A);

  // Output stage: FSM, burst report, lock and sticky fault registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= WAIT_EDGE;
      run         <= 8'd0;
      burst_valid <= 1'b0;
      burst_is_b  <= 1'b0;
      burst_len   <= 8'd0;
      locked      <= 1'b0;
      a_nom_prev  <= 1'b0;
      fault       <= 1'b0;
      fault_code  <= 2'b00;
    end else begin
      state       <= state_nxt;
      run         <= run_nxt;
      burst_valid <= emit;
      if (emit) begin
        burst_is_b <= emit_b;
        burst_len  <= run;
      end

      if (raise) begin
        locked     <= 1'b0;
        a_nom_prev <= 1'b0;
      end else if (emit) begin
        if (!emit_nom)
          locked <= 1'b0;
        else if (emit_b && a_nom_prev)
          locked <= 1'b1;
        a_nom_prev <= !emit_b && emit_nom;
      end

      // The first fault code is kept; a raise coinciding with clear_fault
      // replaces the code instead of being lost.
      if (raise) begin
        fault <= 1'b1;
        if (!fault || clear_fault)
          fault_code <= raise_code;
      end else if (clear_fault) begin
        fault      <= 1'b0;
        fault_code <= 2'b00;
      end
    end
  end

  assign state_A_out = (state == IN_A);
  assign state_B_out = (state == IN_B);

endmodule
